// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Definitions shared by the branch predictor and the
//                prediction resolve queue. It holds the default table index
//                width, the in-flight prediction entry type and a
//                saturating increment helper for the statistic counters.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

  // Default predictor table address width.
  localparam int BP_ADDR_W = 3;

  // One in-flight prediction at the default table width.
  typedef struct packed {
    logic [BP_ADDR_W-1:0] addr;
    logic                 taken;
  } pred_entry_t;

  // Returns v+1, holding at 2^w-1. The counter is carried in 32 bits, so
  // w may be anything from 1 to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? maxv : (v + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pred_fifo
//  Description : Generic DEPTH-entry synchronous FIFO. The head word is
//                always visible on o_data. Occupancy, full and empty are
//                registered. A push is accepted only while not full, and a
//                pop only while not empty. A push into an empty FIFO is
//                never forwarded to a pop in the same cycle. i_flush empties
//                the FIFO and cancels any push or pop in that cycle.
//  Ports       : clk, rst (async, active-high)
//                i_push/i_pop/i_flush, i_data -> o_data (head)
//                o_occupancy, o_full, o_empty
//  Revision    : 1.0  initial release
// ============================================================================
module pred_fifo
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [OCC_W-1:0] w_occ_next;

  assign w_do_push = i_push && !r_full  && !i_flush;
  assign w_do_pop  = i_pop  && !r_empty && !i_flush;

  always_comb begin
    w_occ_next = r_occ;
    if (w_do_push && !w_do_pop)
      w_occ_next = r_occ + OCC_W'(1);
    else if (!w_do_push && w_do_pop)
      w_occ_next = r_occ - OCC_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == C_DEPTH);
      r_empty <= (w_occ_next == '0);
    end
  end

  // The storage needs no reset: the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule
`default_nettype wire

// File: rtl/pred_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pred_resolve_queue
//  Description : In-order queue of issued 1-bit predictions. When the oldest
//                branch resolves, its predicted direction is compared with
//                the actual direction, and a registered update/miss
//                write-back to the predictor table follows one cycle later.
//                Saturating hit and miss counters are kept, along with a
//                sticky orphan error for a resolution that arrives while
//                the queue is empty.
//  Ports       : clk, reset (async, active-high)
//                pred_valid/pred_ready/pred_addr/pred_taken  (issue side)
//                res_valid/res_taken                         (resolve side)
//                upd_valid/upd_addr/upd_taken/upd_miss       (write-back)
//                hit_count, miss_count, occupancy, empty, full, orphan_err
//                flush (only when PRED_FLUSH_EN is defined)
//  Options     : PRED_FLUSH_EN adds a synchronous squash input.
//  Revision    : 1.0  initial release
// ============================================================================
module pred_resolve_queue
  import bp_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = BP_ADDR_W,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PRED_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] pred_addr,
  input  logic              pred_taken,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic              upd_taken,
  output logic              upd_miss,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [OCC_W-1:0]  occupancy,
  output logic              empty,
  output logic              full,
  output logic              orphan_err
);

  logic              w_flush;
  logic              w_pop;
  logic [ADDR_W:0]   w_head;    // {addr, taken}
  logic              w_miss;

  logic              r_upd_valid;
  logic [ADDR_W-1:0] r_upd_addr;
  logic              r_upd_taken;
  logic              r_upd_miss;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;
  logic              r_orphan_err;

`ifdef PRED_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A resolution is only honoured while the queue is non-empty.
  assign w_pop  = res_valid && !empty && !w_flush;
  assign w_miss = (w_head[0] != res_taken);

  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (pred_valid),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_data      ({pred_addr, pred_taken}),
    .o_data      (w_head),
    .o_occupancy (occupancy),
    .o_full      (full),
    .o_empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_valid  <= 1'b0;
      r_upd_addr   <= '0;
      r_upd_taken  <= 1'b0;
      r_upd_miss   <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      if (w_pop) begin
        r_upd_addr  <= w_head[ADDR_W:1];
        r_upd_taken <= res_taken;
        r_upd_miss  <= w_miss;
        if (w_miss)
          r_miss_count <= CNT_W'(sat_inc(32'(r_miss_count), CNT_W));
        else
          r_hit_count  <= CNT_W'(sat_inc(32'(r_hit_count), CNT_W));
      end
      if (res_valid && empty)
        r_orphan_err <= 1'b1;
    end
  end

  assign pred_ready = !full;
  assign upd_valid  = r_upd_valid;
  assign upd_addr   = r_upd_addr;
  assign upd_taken  = r_upd_taken;
  assign upd_miss   = r_upd_miss;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign orphan_err = r_orphan_err;

endmodule
`default_nettype wire

// File: tb/tb_pred_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pred_resolve_queue
//  Description : Directed self-checking bench for pred_resolve_queue
//                (DEPTH=4, ADDR_W=3, CNT_W=16). The flush scenario is
//                included when PRED_FLUSH_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pred_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
`ifdef PRED_FLUSH_EN
  logic        flush;
`endif
  logic        pred_valid;
  logic        pred_ready;
  logic [2:0]  pred_addr;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        upd_valid;
  logic [2:0]  upd_addr;
  logic        upd_taken;
  logic        upd_miss;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [2:0]  occupancy;
  logic        empty;
  logic        full;
  logic        orphan_err;

  int errors = 0;
  int checks = 0;

  pred_resolve_queue #(.DEPTH(4), .ADDR_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PRED_FLUSH_EN
    .flush      (flush),
`endif
    .pred_valid (pred_valid),
    .pred_ready (pred_ready),
    .pred_addr  (pred_addr),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .upd_taken  (upd_taken),
    .upd_miss   (upd_miss),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .occupancy  (occupancy),
    .empty      (empty),
    .full       (full),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [2:0] a, input logic t);
    pred_valid = 1'b1; pred_addr = a; pred_taken = t;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic do_pop(input logic t);
    res_valid = 1'b1; res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
`ifdef PRED_FLUSH_EN
    flush = 1'b0;
`endif
    pred_valid = 1'b0; pred_addr = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
    checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", pred_ready); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    checks++; if ({upd_valid, upd_addr, upd_taken, upd_miss} !== 6'd0) begin errors++; $display("FAIL rst_upd: got %b want 000000", {upd_valid, upd_addr, upd_taken, upd_miss}); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b want 0", orphan_err); end
  endtask

  task automatic test_hit();
    do_push(3'd1, 1'b1);
    checks++; if (occupancy !== 3'd1 || empty !== 1'b0) begin errors++; $display("FAIL hit_occ: got %0d/%b want 1/0", occupancy, empty); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL hit_noupd_before: got %b want 0", upd_valid); end
    do_pop(1'b1);
    checks++; if ({upd_valid, upd_addr, upd_taken, upd_miss} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL hit_upd: got %b want 100110", {upd_valid, upd_addr, upd_taken, upd_miss}); end
    checks++; if (hit_count !== 16'd1 || miss_count !== 16'd0) begin errors++; $display("FAIL hit_counts: got %0d/%0d want 1/0", hit_count, miss_count); end
    tick();
    checks++; if (upd_valid !== 1'b0 || upd_addr !== 3'd1) begin errors++; $display("FAIL hit_pulse: got v=%b a=%0d want v=0 a=1", upd_valid, upd_addr); end
  endtask

  task automatic test_miss();
    do_push(3'd2, 1'b0);
    do_pop(1'b1);
    checks++; if ({upd_valid, upd_addr, upd_taken, upd_miss} !== {1'b1, 3'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL miss_upd: got %b want 101011", {upd_valid, upd_addr, upd_taken, upd_miss}); end
    checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin errors++; $display("FAIL miss_counts: got %0d/%0d want 1/1", hit_count, miss_count); end
  endtask

  task automatic test_full_wrap();
    logic [2:0] exp_a [4];
    logic       exp_m [4];
    exp_a[0] = 3'd3; exp_a[1] = 3'd4; exp_a[2] = 3'd5; exp_a[3] = 3'd6;
    exp_m[0] = 1'b0; exp_m[1] = 1'b1; exp_m[2] = 1'b0; exp_m[3] = 1'b1;
    for (int i = 0; i < 4; i++) do_push(exp_a[i], (i % 2) == 0);
    checks++; if (full !== 1'b1 || pred_ready !== 1'b0 || occupancy !== 3'd4) begin errors++; $display("FAIL full_flags: got f=%b r=%b o=%0d want 1/0/4", full, pred_ready, occupancy); end
    do_push(3'd7, 1'b1);
    checks++; if (occupancy !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_ignore: got o=%0d f=%b want 4/1", occupancy, full); end
    for (int i = 0; i < 4; i++) begin
      do_pop(1'b1);
      checks++; if (upd_valid !== 1'b1 || upd_addr !== exp_a[i] || upd_miss !== exp_m[i]) begin errors++; $display("FAIL full_pop%0d: got v=%b a=%0d m=%b want 1/%0d/%b", i, upd_valid, upd_addr, upd_miss, exp_a[i], exp_m[i]); end
    end
    checks++; if (empty !== 1'b1 || occupancy !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL full_drain: got e=%b o=%0d f=%b want 1/0/0", empty, occupancy, full); end
    checks++; if (hit_count !== 16'd3 || miss_count !== 16'd3) begin errors++; $display("FAIL full_counts: got %0d/%0d want 3/3", hit_count, miss_count); end
  endtask

  task automatic test_back_to_back();
    do_push(3'd1, 1'b0);
    do_push(3'd2, 1'b1);
    pred_valid = 1'b1; pred_addr = 3'd3; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL b2b_occ: got %0d want 2", occupancy); end
    checks++; if ({upd_valid, upd_addr, upd_miss} !== {1'b1, 3'd1, 1'b0}) begin errors++; $display("FAIL b2b_upd: got v=%b a=%0d m=%b want 1/1/0", upd_valid, upd_addr, upd_miss); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %b want 0", upd_valid); end
    do_pop(1'b1);
    checks++; if (upd_addr !== 3'd2 || upd_miss !== 1'b0) begin errors++; $display("FAIL b2b_order1: got a=%0d m=%b want 2/0", upd_addr, upd_miss); end
    do_pop(1'b0);
    checks++; if (upd_addr !== 3'd3 || upd_miss !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL b2b_order2: got a=%0d m=%b e=%b want 3/1/1", upd_addr, upd_miss, empty); end
    checks++; if (hit_count !== 16'd5 || miss_count !== 16'd4) begin errors++; $display("FAIL b2b_counts: got %0d/%0d want 5/4", hit_count, miss_count); end
  endtask

  task automatic test_orphan();
    do_pop(1'b1);
    checks++; if (orphan_err !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL orphan_set: got o=%b v=%b want 1/0", orphan_err, upd_valid); end
    checks++; if (hit_count !== 16'd5 || miss_count !== 16'd4) begin errors++; $display("FAIL orphan_counts: got %0d/%0d want 5/4", hit_count, miss_count); end
    // Push and resolve together while empty: the push is stored, the pop is an orphan.
    pred_valid = 1'b1; pred_addr = 3'd5; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    checks++; if (upd_valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL orphan_nobypass: got v=%b o=%0d want 0/1", upd_valid, occupancy); end
    tick(); tick();
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", orphan_err); end
    do_pop(1'b1);
    checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd5 || hit_count !== 16'd6) begin errors++; $display("FAIL orphan_later_pop: got v=%b a=%0d h=%0d want 1/5/6", upd_valid, upd_addr, hit_count); end
  endtask

`ifdef PRED_FLUSH_EN
  task automatic test_flush();
    do_push(3'd1, 1'b1);
    do_push(3'd2, 1'b1);
    do_push(3'd3, 1'b0);
    flush = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
    pred_valid = 1'b1; pred_addr = 3'd4; pred_taken = 1'b1;
    tick();
    flush = 1'b0; res_valid = 1'b0; pred_valid = 1'b0;
    checks++; if (empty !== 1'b1 || occupancy !== 3'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got e=%b o=%0d v=%b want 1/0/0", empty, occupancy, upd_valid); end
    checks++; if (hit_count !== 16'd6 || miss_count !== 16'd4 || orphan_err !== 1'b1) begin errors++; $display("FAIL flush_retain: got %0d/%0d/%b want 6/4/1", hit_count, miss_count, orphan_err); end
  endtask
`endif

  task automatic test_reset_mid();
    do_push(3'd6, 1'b1);
    do_push(3'd7, 1'b0);
    do_push(3'd2, 1'b1);
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL rmid_occ_before: got %0d want 3", occupancy); end
    res_valid = 1'b1; res_taken = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (empty !== 1'b1 || occupancy !== 3'd0 || full !== 1'b0 || pred_ready !== 1'b1) begin errors++; $display("FAIL rmid_queue: got e=%b o=%0d f=%b r=%b want 1/0/0/1", empty, occupancy, full, pred_ready); end
    checks++; if ({upd_valid, upd_addr, upd_taken, upd_miss} !== 6'd0 || orphan_err !== 1'b0) begin errors++; $display("FAIL rmid_regs: got upd=%b o=%b want 000000/0", {upd_valid, upd_addr, upd_taken, upd_miss}, orphan_err); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    res_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    checks++; if (upd_valid !== 1'b0 || empty !== 1'b1 || orphan_err !== 1'b0) begin errors++; $display("FAIL rmid_after: got v=%b e=%b o=%b want 0/1/0", upd_valid, empty, orphan_err); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_full_wrap();
    test_back_to_back();
    test_orphan();
`ifdef PRED_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pred_resolve_queue.md
Name: pred_resolve_queue

Overview:
- Sits directly downstream of the 1-bit predictor.
- Holds each issued prediction (addr, predicted direction) in an in-order queue until the branch resolves.
- On resolution, compares predicted vs actual and drives a registered update/miss write-back to the predictor table.
- Keeps saturating hit/miss statistics for accuracy measurement.

Parameters:
- DEPTH, 4, number of in-flight predictions held; power of 2, at least 2.
- ADDR_W, 3, predictor table address width.
- CNT_W, 16, width of hit/miss statistic counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  predictor issues a prediction this cycle.
- pred_ready  out  1  queue can accept; equals !full.
- pred_addr  in  ADDR_W  table index of predicted branch.
- pred_taken  in  1  predicted direction.
- res_valid  in  1  oldest in-flight branch resolves this cycle.
- res_taken  in  1  actual direction.
- upd_valid  out  1  write-back strobe to predictor table.
- upd_addr  out  ADDR_W  entry to update.
- upd_taken  out  1  new 1-bit state (= res_taken).
- upd_miss  out  1  prediction was wrong.
- hit_count  out  CNT_W  correct predictions, saturating.
- miss_count  out  CNT_W  mispredictions, saturating.
- occupancy  out  clog2(DEPTH)+1  entries held.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == DEPTH.
- orphan_err  out  1  sticky: res_valid seen while empty.

Behaviour:
- Reset (async, immediate): queue empty, read/write pointers 0, occupancy 0, empty=1, full=0, pred_ready=1, upd_valid=0, upd_addr=0, upd_taken=0, upd_miss=0, hit_count=0, miss_count=0, orphan_err=0.
- Reset mid-operation discards all in-flight entries. No write-back is generated for discarded entries.
- Push: pred_valid && pred_ready at a rising edge writes {pred_addr, pred_taken} at the write pointer. Pointer wraps modulo DEPTH.
- pred_valid while full: ignored, nothing stored. Upstream must hold off while pred_ready=0.
- Pop: res_valid && !empty at a rising edge pops the head entry. Registered outputs on the same edge:
  - upd_valid=1
  - upd_addr = head addr
  - upd_taken = res_taken
  - upd_miss = (head taken != res_taken)
- Write-back latency: upd_* are visible in the cycle after res_valid is sampled. upd_valid is a one-cycle pulse per pop; otherwise 0. upd_addr/upd_taken/upd_miss hold their last values when upd_valid=0.
- Statistics: on each pop, hit_count increments if the prediction matched, else miss_count increments. Both saturate at 2^CNT_W-1.
- Simultaneous push and pop:
  - Not full: both occur; occupancy unchanged.
  - Full: pred_ready=0, so only the pop occurs.
  - Empty: the pop is an orphan. The pushed entry is not bypassed to the pop.
- Orphan: res_valid while empty sets orphan_err=1 (cleared only by reset). No pop, no upd_valid, counters unchanged.
- occupancy, full and empty are registered and update on the same edge as the push/pop.

Optional Feature:
- Macro: PRED_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit), synchronous to clk.
  - flush=1 at an edge empties the queue (pointers and occupancy to 0) and suppresses any push or pop in that cycle.
  - upd_valid=0 on the following cycle.
  - Statistics and orphan_err are retained.
  - Models a pipeline squash after a mispredict.
- Undefined: no flush port; the queue empties only through pops or reset.

Decomposition:
- Shared package bp_pkg holds:
  - ADDR_W default constant.
  - Typedef pred_entry_t {addr[ADDR_W-1:0], taken}, shared with the predictor block.
  - Saturating-increment function.
- One natural sub-module: pred_fifo, a generic DEPTH-entry synchronous FIFO with push/pop, occupancy, full and empty. pred_resolve_queue adds the compare, write-back register, counters and error flag around it.

Test Plan:
- Push addr=1 taken=1, then res_valid res_taken=1 -> next cycle upd_valid=1, upd_addr=1, upd_taken=1, upd_miss=0; hit_count=1, miss_count=0.
- Push addr=2 taken=0, resolve taken=1 -> upd_addr=2, upd_taken=1, upd_miss=1; miss_count=1.
- Push 4 entries with DEPTH=4 -> full=1, pred_ready=0; a 5th push is ignored. Pop 4 -> upd_addr sequence matches push order (FIFO with wrap), empty=1.
- With occupancy=2, push and pop in the same cycle -> occupancy stays 2, one upd_valid pulse, order preserved.
- res_valid while empty -> orphan_err=1 and stays 1; no upd_valid; counters unchanged; only reset clears it.
- Assert reset with 3 entries queued and a pop pending -> all outputs take reset values immediately (before the next clk edge); no upd_valid afterwards. With PRED_FLUSH_EN defined, flush with 3 entries queued -> empty=1 next cycle, hit_count/miss_count unchanged.
